// File: rtl/idelay_load_sequencer.sv
// Loads per-lane fine delays over a shared bus, then issues one common set and a settle hold-off.
// Define IDELAY_SEQ_READBACK_EN to add staged/committed per-lane delay registers with readback.
module idelay_load_sequencer #(
  parameter int unsigned NUM_LANES     = 8,
  parameter int unsigned LANE_BITS     = 3,
  parameter int unsigned SET_GAP       = 1,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [LANE_BITS-1:0] cmd_lane_i,
  input  logic [7:0]           cmd_delay_i,
  input  logic                 cmd_last_i,
  output logic [7:0]           dly_data_o,
  output logic [NUM_LANES-1:0] dly_ld_o,
  output logic                 dly_set_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  input  logic [LANE_BITS-1:0] rd_lane_i,
  output logic [7:0]           rd_delay_o
);

  typedef enum logic [2:0] {IDLE, LOAD, GAP, SET, SETTLE} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [7:0]             dly_data_q, dly_data_d;
  logic [NUM_LANES-1:0]   dly_ld_q, dly_ld_d;
  logic                   set_q, set_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   cmd_fire;
  logic                   lane_ok;

  assign cmd_ready_o = (state_q == IDLE) || (state_q == LOAD);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign lane_ok     = 32'(cmd_lane_i) < NUM_LANES;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, LOAD: begin
        if (cmd_fire) begin
          if (cmd_last_i) begin
            if (SET_GAP > 0) begin
              state_d = GAP;
              cnt_d   = 8'(SET_GAP - 1);
            end else begin
              state_d = SET;
            end
          end else begin
            state_d = LOAD;
          end
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) state_d = SET;
        else               cnt_d   = cnt_q - 8'd1;
      end
      SET: begin
        // The set strobe is registered, so the first SETTLE cycle is the set cycle itself.
        state_d = SETTLE;
        cnt_d   = 8'(SETTLE_CYCLES);
      end
      SETTLE: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dly_data_d = cmd_fire ? cmd_delay_i : dly_data_q;
    err_d      = cmd_fire && !lane_ok;
    set_d      = (state_q == SET);
    done_d     = (state_q == SETTLE) && (cnt_q == 8'd0);
    dly_ld_d   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      dly_ld_d[i] = cmd_fire && (cmd_lane_i == LANE_BITS'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      dly_data_q <= 8'd0;
      dly_ld_q   <= '0;
      set_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dly_data_q <= dly_data_d;
      dly_ld_q   <= dly_ld_d;
      set_q      <= set_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign dly_data_o = dly_data_q;
  assign dly_ld_o   = dly_ld_q;
  assign dly_set_o  = set_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != IDLE);

`ifdef IDELAY_SEQ_READBACK_EN
  logic [7:0] stage_q  [NUM_LANES];
  logic [7:0] shadow_q [NUM_LANES];
  logic [7:0] rd_delay_q, rd_delay_d;

  always_comb begin
    rd_delay_d = 8'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rd_lane_i == LANE_BITS'(i)) rd_delay_d = shadow_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        stage_q[i]  <= 8'd0;
        shadow_q[i] <= 8'd0;
      end
      rd_delay_q <= 8'd0;
    end else begin
      // Staging follows the ld strobes; shadows only move on the common set.
      for (int i = 0; i < NUM_LANES; i++) begin
        if (dly_ld_d[i]) stage_q[i]  <= cmd_delay_i;
        if (set_q)       shadow_q[i] <= stage_q[i];
      end
      rd_delay_q <= rd_delay_d;
    end
  end

  assign rd_delay_o = rd_delay_q;
`else
  logic unused_rd_lane;
  assign unused_rd_lane = ^rd_lane_i;
  assign rd_delay_o     = 8'd0;
`endif

endmodule

// File: tb/tb_idelay_load_sequencer.sv
// Scoreboard bench: the driver pushes expected strobe events per accepted command, a negedge monitor checks them.
module tb_idelay_load_sequencer;
  localparam int NL  = 6;
  localparam int LB  = 3;
  localparam int GAP = 1;
  localparam int STL = 4;
  localparam int INF = 1 << 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LB-1:0] cmd_lane = '0;
  logic [7:0]    cmd_delay = '0;
  logic          cmd_last = 1'b0;
  logic [7:0]    dly_data;
  logic [NL-1:0] dly_ld;
  logic          dly_set, busy, done, err;
  logic [LB-1:0] rd_lane = '0;
  logic [7:0]    rd_delay;

  always #5 clk = ~clk;

  idelay_load_sequencer #(.NUM_LANES(NL), .LANE_BITS(LB), .SET_GAP(GAP), .SETTLE_CYCLES(STL)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_lane_i(cmd_lane),
    .cmd_delay_i(cmd_delay), .cmd_last_i(cmd_last),
    .dly_data_o(dly_data), .dly_ld_o(dly_ld), .dly_set_o(dly_set),
    .busy_o(busy), .done_o(done), .err_o(err),
    .rd_lane_i(rd_lane), .rd_delay_o(rd_delay)
  );

  typedef struct {
    int         cyc;
    bit         is_ld;
    logic [7:0] ld;
    logic       err, set, done;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         grp_lo = INF, grp_hi = INF, rdy_lo = INF;
  bit         in_grp = 0;
  logic [7:0] exp_data = 8'd0;
  logic [7:0] exp_rd = 8'd0;
  logic [7:0] stage_m  [NL];
  logic [7:0] shadow_m [NL];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // Reference: each accept in cycle c gives ld at c+1; a last also gives set SET_GAP+1 after ld and done SETTLE+1 after set.
  function automatic void accept(input int c, input logic [LB-1:0] lane, input logic [7:0] d, input bit last);
    ev_t e;
    int  sc, dc;
    if (!in_grp) begin
      in_grp = 1; grp_lo = c + 1; grp_hi = INF; rdy_lo = INF;
    end
    e.cyc = c + 1; e.is_ld = 1; e.err = (lane >= NL); e.set = 0; e.done = 0; e.data = d;
    e.ld  = (lane < NL) ? 8'(1 << lane) : 8'h00;
    exp_q.push_back(e);
    if (lane < NL) stage_m[lane] = d;
    if (last) begin
      sc = c + 2 + GAP;
      dc = sc + STL + 1;
      e.is_ld = 0; e.ld = 8'h00; e.err = 0; e.data = 8'h00;
      e.cyc = sc; e.set = 1; e.done = 0; exp_q.push_back(e);
      e.cyc = dc; e.set = 0; e.done = 1; exp_q.push_back(e);
      grp_hi = dc; rdy_lo = c + 1; in_grp = 0;
    end
  endfunction

  always @(negedge clk) begin
    logic [7:0] s_ld;
    logic       s_err, s_set, s_done;
    ev_t        e;
    s_ld = 8'h00; s_err = 0; s_set = 0; s_done = 0;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("event_cycle", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      s_ld = e.ld; s_err = e.err; s_set = e.set; s_done = e.done;
      if (e.is_ld) exp_data = e.data;
    end
    chk("strobes{ld,err,set,done}", {8'(dly_ld), err, dly_set, done}, {s_ld, s_err, s_set, s_done});
    chk("dly_data", dly_data, exp_data);
    chk("busy", busy, (cyc >= grp_lo && cyc < grp_hi));
    chk("cmd_ready", cmd_ready, !(cyc >= rdy_lo && cyc < grp_hi));
    chk("rd_delay", rd_delay, exp_rd);
`ifdef IDELAY_SEQ_READBACK_EN
    exp_rd = (rd_lane < NL) ? shadow_m[rd_lane] : 8'h00;
    if (s_set) shadow_m = stage_m;
`else
    exp_rd = 8'h00;
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cmd_valid = 0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [LB-1:0] lane, input logic [7:0] d, input bit last);
    int w = 0;
    cmd_valid = 1; cmd_lane = lane; cmd_delay = d; cmd_last = last;
    while (!cmd_ready && w < 200) begin
      tick();
      w++;
    end
    chk("send_ready_timeout", cmd_ready, 1);
    if (!cmd_ready) begin
      cmd_valid = 0;
      return;
    end
    accept(cyc, lane, d, last);
    tick();
  endtask

  task automatic clear_model();
    exp_q.delete();
    in_grp = 0; grp_lo = INF; grp_hi = INF; rdy_lo = INF;
    exp_data = 8'd0; exp_rd = 8'd0;
    foreach (stage_m[i]) begin
      stage_m[i] = 8'd0;
      shadow_m[i] = 8'd0;
    end
  endtask

  initial begin
    int n;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    tick();

    rd_lane = 3'd2;
    send(3'd2, 8'h2B, 1);
    idle(10);

    send(3'd0, 8'h11, 0); send(3'd1, 8'h22, 0); send(3'd2, 8'h33, 0); send(3'd3, 8'h44, 1);
    idle(12);

    send(3'd7, 8'h5A, 1);
    idle(10);

    rd_lane = 3'd5;
    send(3'd5, 8'hC7, 1);
    idle(10);

    // Reset while sitting in the gap between the last ld and the set.
    send(3'd4, 8'h9E, 1);
    @(negedge clk);
    #2;
    rst_n = 0; cmd_valid = 0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    idle(6);

    repeat (40) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        rd_lane = LB'($urandom);
        send(LB'($urandom_range(0, 7)), 8'($urandom), i == n - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
    end
    idle(20);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
